// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared defaults and FSM state type for the I2S DAC serializer
package audio_pkg;

  localparam int DATA_W_DEFAULT     = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Slot sequencing: idle until a left start, one-bit I2S delay, data bits, zero padding.
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    DLY       = 2'd1,
    SHIFT     = 2'd2,
    PAD       = 2'd3
  } dac_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - stereo frame buffer with registered ready and level output
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  // DEPTH must be a power of two so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level_next;
  logic             push;
  logic             pop;

  assign push    = wr_valid && wr_ready;
  assign pop     = rd_en && !empty;
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle; a simultaneous push and pop cancel out.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end
  end

  // Pointer, level and ready registers; ready reflects the level that will hold next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level    <= level_next;
      wr_ready <= (level_next < FULL_LEVEL);
    end
  end

  // Frame storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - buffers stereo frames and shifts them out as I2S to a master codec
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [DATA_W-1:0]             sample_left,
  input  logic [DATA_W-1:0]             sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          audio_BCLK,
  input  logic                          audio_DACLRCK,
  output logic                          audio_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_count
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  dac_state_t state;
  dac_state_t state_next;

  logic [2:0]          bclk_sync;
  logic [1:0]          lrck_sync;
  logic                lrck;
  logic                lrck_prev;
  logic                bclk_fall;
  logic                lr_change;
  logic                left_start;

  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   right_latch;
  logic [CNT_W-1:0]    bit_cnt;

  logic                load_left;
  logic                load_right;
  logic                shift_en;
  logic                dat_next;

  logic [2*DATA_W-1:0] fifo_rd_data;
  logic                fifo_empty;
  logic                underrun_evt;

  sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_clk),
    .resetn   (reset_reset_n),
    .wr_data  ({sample_left, sample_right}),
    .wr_valid (sample_valid),
    .wr_ready (sample_ready),
    .rd_en    (load_left),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Bit [2] of the BCLK chain only serves as edge history; LRCK rides the same two-flop delay.
  assign bclk_fall    = bclk_sync[2] & ~bclk_sync[1];
  assign lrck         = lrck_sync[1];
  assign lr_change    = bclk_fall && (lrck != lrck_prev);
  assign left_start   = lr_change && !lrck;
  assign underrun_evt = load_left && fifo_empty;

  // Bring the codec clocks into clk_clk and remember LRCK as of the last BCLK falling edge.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], audio_BCLK};
      lrck_sync <= {lrck_sync[0], audio_DACLRCK};
      if (bclk_fall) begin
        lrck_prev <= lrck;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next state, next serial bit and datapath strobes; nothing moves except on a BCLK fall.
  always_comb begin
    state_next = state;
    dat_next   = audio_DACDAT;
    load_left  = 1'b0;
    load_right = 1'b0;
    shift_en   = 1'b0;
    if (bclk_fall) begin
      if (state == WAIT_SYNC) begin
        dat_next = 1'b0;
        if (left_start) begin
          load_left  = 1'b1;
          state_next = DLY;
        end
      end else if (lr_change) begin
        // Any LRCK edge restarts the slot, truncating whatever was still being shifted.
        load_left  = !lrck;
        load_right = lrck;
        dat_next   = 1'b0;
        state_next = DLY;
      end else begin
        case (state)
          DLY: begin
            dat_next   = shreg[DATA_W-1];
            shift_en   = 1'b1;
            state_next = SHIFT;
          end
          SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
              dat_next   = 1'b0;
              state_next = PAD;
            end else begin
              dat_next = shreg[DATA_W-1];
              shift_en = 1'b1;
            end
          end
          default: begin
            dat_next = 1'b0;
          end
        endcase
      end
    end
  end

  // Shift register, right-word latch, bit counter and the registered serial output.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      shreg        <= '0;
      right_latch  <= '0;
      bit_cnt      <= '0;
      audio_DACDAT <= 1'b0;
    end else begin
      audio_DACDAT <= dat_next;
      if (load_left) begin
        shreg       <= fifo_empty ? '0 : fifo_rd_data[2*DATA_W-1:DATA_W];
        right_latch <= fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
        bit_cnt     <= '0;
      end else if (load_right) begin
        shreg   <= right_latch;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_ONE;
      end
    end
  end

  // Underrun pulse and its saturating counter.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= underrun_evt;
      if (underrun_evt && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - self-checking bench for audio_dac_serializer
module tb_audio_dac_serializer;

  localparam int HALF = 8;

  logic        clk;
  logic        reset_n;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        lrck;
  logic        dacdat;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks = 0;
  int errors = 0;
  int ur_pulses = 0;

  logic [31:0] m_q[$];
  logic        m_prev_lr = 1'b0;
  logic        m_active = 1'b0;
  logic [15:0] m_right = '0;
  int          exp_pulses = 0;
  int          exp_cnt = 0;

  audio_dac_serializer dut (
    .clk_clk        (clk),
    .reset_reset_n  (reset_n),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .audio_BCLK     (bclk),
    .audio_DACLRCK  (lrck),
    .audio_DACDAT   (dacdat),
    .fifo_level     (fifo_level),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (underrun === 1'b1) ur_pulses++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected I2S slot of n bits: one delay bit, word MSB first, then zeros.
  function automatic logic [63:0] slot_bits(input logic [15:0] w, input int n);
    logic [63:0] v;
    logic        b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      if (i >= 1 && i <= 16) b = w[16 - i];
      v = {v[62:0], b};
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_q.delete();
    m_prev_lr = 1'b0;
    m_active = 1'b0;
    m_right = '0;
    exp_cnt = 0;
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    int waited;
    waited = 0;
    @(negedge clk);
    sample_left = l;
    sample_right = r;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: ready=%b required 1 within 50 cycles", sample_ready);
    end else begin
      m_q.push_back({l, r});
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Drive one LRCK half of nbits BCLK periods, capture DACDAT at each rising edge and compare.
  task automatic codec_half(input logic lr, input int nbits, input logic do_push,
                            input logic [15:0] pl, input logic [15:0] pr, input string name);
    logic [63:0] cap;
    logic [63:0] expv;
    logic [15:0] word;
    logic [31:0] f;
    logic        driven;
    cap = '0;
    word = '0;
    driven = 1'b0;
    if (lr != m_prev_lr) begin
      if (!lr) begin
        m_active = 1'b1;
        driven = 1'b1;
        if (m_q.size() == 0) begin
          word = '0;
          m_right = '0;
          exp_pulses++;
          if (exp_cnt < 65535) exp_cnt++;
        end else begin
          f = m_q.pop_front();
          word = f[31:16];
          m_right = f[15:0];
        end
      end else if (m_active) begin
        word = m_right;
        driven = 1'b1;
      end
    end
    m_prev_lr = lr;
    expv = driven ? slot_bits(word, nbits) : 64'd0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bclk = 1'b0;
      lrck = lr;
      for (int j = 1; j <= HALF; j++) begin
        @(negedge clk);
        if (do_push && i == 0 && j == 2) begin
          sample_left = pl;
          sample_right = pr;
          sample_valid = 1'b1;
          m_q.push_back({pl, pr});
        end
        if (do_push && i == 0 && j == 3) sample_valid = 1'b0;
      end
      cap = {cap[62:0], dacdat};
      bclk = 1'b1;
      repeat (HALF - 1) @(negedge clk);
    end
    checks++;
    if (cap !== expv) begin
      errors++;
      $display("FAIL %s: dacdat bits %h required %h", name, cap, expv);
    end
  endtask

  task automatic run_frame(input int n, input string name);
    codec_half(1'b0, n, 1'b0, 16'h0, 16'h0, {name, "_left"});
    codec_half(1'b1, n, 1'b0, 16'h0, 16'h0, {name, "_right"});
  endtask

  task automatic check_underruns(input string name);
    checks++;
    if (underrun_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_count: underrun_count=%0d required %0d", name, underrun_count, exp_cnt);
    end
    checks++;
    if (ur_pulses != exp_pulses) begin
      errors++;
      $display("FAIL %s_pulses: underrun pulse cycles=%0d required %0d", name, ur_pulses, exp_pulses);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b required 0", sample_ready); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: %0d required 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: %b required 0", underrun); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_count: %0d required 0", underrun_count); end
    checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: %b required 0", dacdat); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL release_ready: %b required 1", sample_ready); end
  endtask

  task automatic test_underrun_first();
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "prime_right");
    run_frame(32, "empty_frame");
    check_underruns("first_underrun");
  endtask

  task automatic test_basic_pattern();
    push_frame(16'h8001, 16'h7FFE);
    run_frame(32, "pattern_8001_7ffe");
    for (int k = 0; k < 3; k++) push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    for (int k = 0; k < 3; k++) run_frame(32, "random_frame");
    check_underruns("basic");
  endtask

  task automatic test_short_frames();
    for (int k = 0; k < 3; k++) push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    run_frame(10, "short_10");
    run_frame(17, "exact_17");
    run_frame(32, "after_short");
    check_underruns("short");
  endtask

  task automatic test_fill();
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (k < 5) begin
        sample_left = 16'h1000 + 16'(k);
        sample_right = 16'h2000 + 16'(k);
        sample_valid = 1'b1;
        if (sample_ready === 1'b1) begin
          m_q.push_back({sample_left, sample_right});
          k++;
        end
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL fill_accepted: %0d frames required 4", k); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: %b required 0", sample_ready); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fill_level: %0d required 4", fifo_level); end
    sample_valid = 1'b0;
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "fill_prime");
    codec_half(1'b0, 32, 1'b0, 16'h0, 16'h0, "fill_left0");
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL fill_pop_level: %0d required 3", fifo_level); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL fill_pop_ready: %b required 1", sample_ready); end
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "fill_right0");
    for (int n = 0; n < 3; n++) run_frame(32, "fill_drain");
    check_underruns("fill");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 2; n++) push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "b2b_prime");
    for (int n = 0; n < 8; n++) begin
      codec_half(1'b0, 32, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), "b2b_left");
      checks++;
      if (fifo_level !== 3'd2) begin
        errors++;
        $display("FAIL b2b_level: %0d required 2 after push+pop", fifo_level);
      end
      codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "b2b_right");
    end
    run_frame(32, "b2b_drain");
    run_frame(32, "b2b_drain");
    check_underruns("b2b");
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_frame(16'hA5C3, 16'h3C5A);
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "midrst_prime");
    codec_half(1'b0, 8, 1'b0, 16'h0, 16'h0, "midrst_partial");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL midrst_dacdat: %b required 0", dacdat); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_q.delete();
    m_prev_lr = 1'b0;
    m_active = 1'b0;
    m_right = '0;
    exp_cnt = 0;
    @(negedge clk);
    checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL midrst_release_dacdat: %b required 0", dacdat); end
    push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    codec_half(1'b0, 24, 1'b0, 16'h0, 16'h0, "midrst_left_rest");
    codec_half(1'b1, 32, 1'b0, 16'h0, 16'h0, "midrst_right_idle");
    run_frame(32, "midrst_restart");
    check_underruns("midrst");
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.underrun_count = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_count;
    exp_cnt = 65534;
    run_frame(32, "sat_first");
    check_underruns("sat_reach");
    run_frame(32, "sat_second");
    check_underruns("sat_hold");
  endtask

  initial begin
    reset_n = 1'b0;
    sample_left = '0;
    sample_right = '0;
    sample_valid = 1'b0;
    bclk = 1'b1;
    lrck = 1'b0;
    test_reset();
    test_underrun_first();
    test_basic_pattern();
    test_short_frames();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per channel sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning stereo frames buffered (power of 2).
REQ-003 SHALL have port clk_clk  in  1  system clock; must be at least 8x audio_BCLK frequency.
REQ-004 SHALL have port reset_reset_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port sample_left  in  DATA_W  left sample, two's complement.
REQ-006 SHALL have port sample_right  in  DATA_W  right sample, two's complement.
REQ-007 SHALL have port sample_valid  in  1  stereo frame offered.
REQ-008 SHALL have port sample_ready  out  1  frame accepted when valid&&ready at clk_clk rising edge.
REQ-009 SHALL have port audio_BCLK  in  1  codec bit clock, codec is master, asynchronous.
REQ-010 SHALL have port audio_DACLRCK  in  1  codec LR clock; 0 = left, 1 = right; asynchronous.
REQ-011 SHALL have port audio_DACDAT  out  1  I2S serial data to codec.
REQ-012 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  frames held, 0..FIFO_DEPTH.
REQ-013 SHALL have port underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-014 SHALL have port underrun_count  out  16  saturating count of underruns.

Function
REQ-015 SHALL synchronise audio_BCLK and audio_DACLRCK with two flops each, then detect BCLK falling edges on the synchronised copy.
REQ-016 SHALL sample the synchronised LRCK only at detected BCLK falling edges and compare it with the value from the previous falling edge to detect frame starts.
REQ-017 SHALL run the FSM states WAIT_SYNC, DLY, SHIFT and PAD; all transitions occur only on BCLK falling-edge cycles.
REQ-018 SHALL leave WAIT_SYNC only on an LRCK 1->0 change (left start), entering DLY; audio_DACDAT is held at 0 in WAIT_SYNC.
REQ-019 SHALL, on every LRCK change in DLY/SHIFT/PAD, load the shift register and enter DLY: left word on 1->0, latched right word on 0->1.
REQ-020 SHALL, on a left start, pop one FIFO frame (left to the shift register, right to the right latch); if the FIFO is empty, load zeros for both channels, pulse underrun, and increment underrun_count, saturating at 0xFFFF.
REQ-021 SHALL drive audio_DACDAT from DLY as follows:
- DLY drives 0 (I2S one-bit delay) and goes to SHIFT at the next falling edge.
- SHIFT drives the MSB first, one bit per falling edge, for DATA_W bits, then goes to PAD.
- PAD drives 0 until the next LRCK change.
REQ-022 SHALL update audio_DACDAT no later than 3 clk_clk cycles after the BCLK falling edge at the pin.
REQ-023 SHALL force an early LRCK change (frame shorter than DATA_W+1 BCLKs) to restart per REQ-019; the remaining bits are truncated and no error is flagged.
REQ-024 SHALL implement the FIFO with the following rules:
- sample_ready = (fifo_level < FIFO_DEPTH), registered.
- Push and pop in the same cycle leave fifo_level unchanged.
- A push into a full FIFO is impossible because ready is low.
- Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 SHALL, while reset_reset_n=0 at a clk_clk edge, set:
- FSM = WAIT_SYNC
- audio_DACDAT=0, sample_ready=0, fifo_level=0, underrun=0, underrun_count=0
- the shift register, right latch, FIFO pointers and synchroniser flops to 0.
REQ-026 SHALL set sample_ready=1 on the first cycle after reset release.
REQ-027 SHALL discard a frame in progress on mid-frame reset; output resumes only at the next left start.

Structure
REQ-028 SHALL take DATA_W and FIFO_DEPTH defaults and the FSM state enum from shared package audio_pkg.
REQ-029 SHALL instantiate one sub-module, sample_fifo (2*DATA_W wide, FIFO_DEPTH deep, with level output), holding the buffer.

Verification
REQ-030 SHALL check the following directed scenarios:
- Push L=0x8001, R=0x7FFE with BCLK=3.072 MHz, clk=50 MHz, 32 BCLK per LRCK half: DACDAT shows 0, 1000000000000001, then zeros on left; then 0, 0111111111111110 on right.
- No push before the first left start: underrun pulses once, underrun_count=1, DACDAT all 0 for the frame.
- Push 5 frames back-to-back after reset: ready drops after 4, fifo_level=4; after one left start, level=3 and ready=1.
- Simultaneous push and pop at level 2: level stays 2 and frame order is preserved across pointer wrap (push 10 frames total).
- Reset asserted mid-left-word: DACDAT=0 immediately after reset; the right half following reset is not driven; output restarts at the next LRCK 1->0.
- Force underrun_count to 0xFFFF via 65536 empty frames (or a backdoor preload): the next underrun pulses underrun but the count stays 0xFFFF.
